// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter sharing the single off-chip memory port between the
//   instruction-fetch unit (IFU, read only) and the load/store unit (LSU).
//   The winning request is registered, the memory strobe is held until the
//   controller reports ready, and a one-cycle response pulse goes back to the
//   owner. Only one transaction is outstanding at a time.
//
//   FSM: IDLE -> BUSY -> DRAIN -> IDLE
//     IDLE  : combinational *_req_ready; grant the single valid port, or the
//             port that did not win last time when both are valid.
//     BUSY  : strobe asserted; on mem_io_ready capture data, pulse response.
//     DRAIN : strobes low; wait for mem_io_ready to fall so that a long ready
//             from the controller is not taken as completion of the next access.
//
//   Optional feature (macro MEM_ARB_TIMEOUT_EN):
//     A 16-bit BUSY-cycle counter aborts the access after TIMEOUT_CYCLES cycles
//     without ready, returning resp_err=1 and rdata=0. Without the macro the
//     BUSY state waits indefinitely and *_resp_err stays 0.
//
//   Ports
//     ramclk, rst                       clock (rising edge), sync active-low reset
//     ifu_req_valid/ready/addr          IFU request channel
//     ifu_resp_valid/rdata/err          IFU response channel
//     lsu_req_valid/ready/addr/write/wdata/size   LSU request channel
//     lsu_resp_valid/rdata/err          LSU response channel
//     mem_io_addr/read/write/wdata, io_byte_size  memory request side
//     mem_io_rdata, mem_io_ready        memory response side
//     arb_busy                          FSM is not in IDLE
module mem_port_arbiter #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            ramclk,
    input  logic            rst,
    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [XLEN-1:0] ifu_req_addr,
    output logic            ifu_resp_valid,
    output logic [XLEN-1:0] ifu_resp_rdata,
    output logic            ifu_resp_err,
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [XLEN-1:0] lsu_req_addr,
    input  logic            lsu_req_write,
    input  logic [XLEN-1:0] lsu_req_wdata,
    input  logic [1:0]      lsu_req_size,
    output logic            lsu_resp_valid,
    output logic [XLEN-1:0] lsu_resp_rdata,
    output logic            lsu_resp_err,
    output logic [XLEN-1:0] mem_io_addr,
    output logic            mem_io_read,
    output logic            mem_io_write,
    output logic [XLEN-1:0] mem_io_wdata,
    output logic [1:0]      io_byte_size,
    input  logic [XLEN-1:0] mem_io_rdata,
    input  logic            mem_io_ready,
    output logic            arb_busy
);

    // Elaboration-time parameter sanity checks.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    state_t          state, state_nxt;
    logic            last_grant, last_grant_nxt;
    logic            owner, owner_nxt;
    logic [XLEN-1:0] addr_nxt, wdata_nxt;
    logic            read_nxt, write_nxt;
    logic [1:0]      size_nxt;
    logic            ifu_valid_nxt, lsu_valid_nxt;
    logic [XLEN-1:0] ifu_rdata_nxt, lsu_rdata_nxt;
    logic            ifu_err_nxt, lsu_err_nxt;

`ifdef MEM_ARB_TIMEOUT_EN
    // Abort fires on the edge that ends the TIMEOUT_CYCLES-th BUSY cycle.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt, tmo_cnt_nxt;
`endif

    assign arb_busy = (state != IDLE);

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        owner_nxt      = owner;
        addr_nxt       = mem_io_addr;
        wdata_nxt      = mem_io_wdata;
        read_nxt       = mem_io_read;
        write_nxt      = mem_io_write;
        size_nxt       = io_byte_size;
        ifu_valid_nxt  = 1'b0;
        lsu_valid_nxt  = 1'b0;
        ifu_rdata_nxt  = ifu_resp_rdata;
        lsu_rdata_nxt  = lsu_resp_rdata;
        ifu_err_nxt    = ifu_resp_err;
        lsu_err_nxt    = lsu_resp_err;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_cnt_nxt    = tmo_cnt;
`endif

        case (state)
            IDLE: begin
                // IFU wins when alone, or when both are valid and LSU won last.
                if (ifu_req_valid && (!lsu_req_valid || last_grant == OWN_LSU)) begin
                    ifu_req_ready = 1'b1;
                end else if (lsu_req_valid) begin
                    lsu_req_ready = 1'b1;
                end

                if (ifu_req_ready) begin
                    owner_nxt      = OWN_IFU;
                    last_grant_nxt = OWN_IFU;
                    addr_nxt       = ifu_req_addr;
                    wdata_nxt      = '0;
                    size_nxt       = 2'd0;
                    read_nxt       = 1'b1;
                    write_nxt      = 1'b0;
                    state_nxt      = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                    tmo_cnt_nxt    = '0;
`endif
                end else if (lsu_req_ready) begin
                    owner_nxt      = OWN_LSU;
                    last_grant_nxt = OWN_LSU;
                    addr_nxt       = lsu_req_addr;
                    wdata_nxt      = lsu_req_wdata;
                    size_nxt       = lsu_req_size;
                    read_nxt       = !lsu_req_write;
                    write_nxt      = lsu_req_write;
                    state_nxt      = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                    tmo_cnt_nxt    = '0;
`endif
                end
            end

            BUSY: begin
                if (mem_io_ready) begin
                    read_nxt  = 1'b0;
                    write_nxt = 1'b0;
                    state_nxt = DRAIN;
                    if (owner == OWN_IFU) begin
                        ifu_valid_nxt = 1'b1;
                        ifu_rdata_nxt = mem_io_rdata;
                        ifu_err_nxt   = 1'b0;
                    end else begin
                        lsu_valid_nxt = 1'b1;
                        // Writes return zero data.
                        lsu_rdata_nxt = mem_io_write ? '0 : mem_io_rdata;
                        lsu_err_nxt   = 1'b0;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    read_nxt  = 1'b0;
                    write_nxt = 1'b0;
                    state_nxt = DRAIN;
                    if (owner == OWN_IFU) begin
                        ifu_valid_nxt = 1'b1;
                        ifu_rdata_nxt = '0;
                        ifu_err_nxt   = 1'b1;
                    end else begin
                        lsu_valid_nxt = 1'b1;
                        lsu_rdata_nxt = '0;
                        lsu_err_nxt   = 1'b1;
                    end
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 16'd1;
                end
`endif
            end

            DRAIN: begin
                if (!mem_io_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ramclk) begin
        if (!rst) begin
            state          <= IDLE;
            last_grant     <= OWN_LSU;
            owner          <= OWN_IFU;
            mem_io_addr    <= '0;
            mem_io_wdata   <= '0;
            mem_io_read    <= 1'b0;
            mem_io_write   <= 1'b0;
            io_byte_size   <= 2'd0;
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            ifu_resp_rdata <= '0;
            lsu_resp_rdata <= '0;
            ifu_resp_err   <= 1'b0;
            lsu_resp_err   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
        end else begin
            state          <= state_nxt;
            last_grant     <= last_grant_nxt;
            owner          <= owner_nxt;
            mem_io_addr    <= addr_nxt;
            mem_io_wdata   <= wdata_nxt;
            mem_io_read    <= read_nxt;
            mem_io_write   <= write_nxt;
            io_byte_size   <= size_nxt;
            ifu_resp_valid <= ifu_valid_nxt;
            lsu_resp_valid <= lsu_valid_nxt;
            ifu_resp_rdata <= ifu_rdata_nxt;
            lsu_resp_rdata <= lsu_rdata_nxt;
            ifu_resp_err   <= ifu_err_nxt;
            lsu_resp_err   <= lsu_err_nxt;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt        <= tmo_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Expected responses are queued when a
// request is granted and compared by a monitor whenever a response pulse appears.
module tb_mem_port_arbiter;

    logic        ramclk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req_valid = 1'b0;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr = '0;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_rdata;
    logic        ifu_resp_err;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic [31:0] lsu_req_addr = '0;
    logic        lsu_req_write = 1'b0;
    logic [31:0] lsu_req_wdata = '0;
    logic [1:0]  lsu_req_size = 2'd0;
    logic        lsu_resp_valid;
    logic [31:0] lsu_resp_rdata;
    logic        lsu_resp_err;
    logic [31:0] mem_io_addr;
    logic        mem_io_read;
    logic        mem_io_write;
    logic [31:0] mem_io_wdata;
    logic [1:0]  io_byte_size;
    logic [31:0] mem_io_rdata = '0;
    logic        mem_io_ready = 1'b0;
    logic        arb_busy;

    always #5 ramclk = ~ramclk;

    mem_port_arbiter #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
        .ramclk(ramclk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr), .ifu_resp_valid(ifu_resp_valid),
        .ifu_resp_rdata(ifu_resp_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_addr(lsu_req_addr), .lsu_req_write(lsu_req_write),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_size(lsu_req_size),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata),
        .lsu_resp_err(lsu_resp_err),
        .mem_io_addr(mem_io_addr), .mem_io_read(mem_io_read),
        .mem_io_write(mem_io_write), .mem_io_wdata(mem_io_wdata),
        .io_byte_size(io_byte_size), .mem_io_rdata(mem_io_rdata),
        .mem_io_ready(mem_io_ready), .arb_busy(arb_busy)
    );

    typedef struct packed {
        logic        lsu;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_resp(input logic lsu, input logic [31:0] d, input logic e);
        resp_t r;
        r.lsu   = lsu;
        r.rdata = d;
        r.err   = e;
        exp_q.push_back(r);
    endtask

    // Memory model: ready with data after lat cycles of strobe, held one edge.
    task automatic serve(input int lat, input logic [31:0] data);
        repeat (lat - 1) @(negedge ramclk);
        mem_io_ready = 1'b1;
        mem_io_rdata = data;
        @(negedge ramclk);
        mem_io_ready = 1'b0;
        mem_io_rdata = '0;
        chk("strobe_drop", {mem_io_read, mem_io_write}, 2'b00);
    endtask

    // Response monitor / scoreboard consumer.
    always @(negedge ramclk) begin
        if (ifu_resp_valid === 1'b1 || lsu_resp_valid === 1'b1) begin
            chk("resp_exclusive", ifu_resp_valid & lsu_resp_valid, 0);
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 1, 0);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                chk("resp_owner", {ifu_resp_valid, lsu_resp_valid}, e.lsu ? 2'b01 : 2'b10);
                chk("resp_rdata", e.lsu ? lsu_resp_rdata : ifu_resp_rdata, e.rdata);
                chk("resp_err", e.lsu ? lsu_resp_err : ifu_resp_err, e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (2) @(negedge ramclk);
        chk("rst_read", mem_io_read, 0);
        chk("rst_write", mem_io_write, 0);
        chk("rst_busy", arb_busy, 0);
        chk("rst_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
        chk("rst_rdata", {ifu_resp_rdata, lsu_resp_rdata}, 0);
        chk("rst_ready_idle", {ifu_req_ready, lsu_req_ready}, 0);
        rst = 1'b1;

        // IFU only read, memory answers after 3 cycles
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h100;
        #1 chk("t1_ifu_ready", {ifu_req_ready, lsu_req_ready}, 2'b10);
        expect_resp(1'b0, 32'hDEADBEEF, 1'b0);
        @(negedge ramclk);
        ifu_req_valid = 1'b0;
        ifu_req_addr  = 32'hFFFF_FFFF;
        chk("t1_read", {mem_io_read, mem_io_write}, 2'b10);
        chk("t1_addr", mem_io_addr, 32'h100);
        chk("t1_size", io_byte_size, 0);
        chk("t1_busy", arb_busy, 1);
        #1 chk("t1_no_ready_busy", ifu_req_ready, 0);
        serve(3, 32'hDEADBEEF);
        @(negedge ramclk);
        chk("t1_pulse_len", ifu_resp_valid, 0);
        chk("t1_rdata_hold", ifu_resp_rdata, 32'hDEADBEEF);
        chk("t1_idle", arb_busy, 0);

        // Both valid right after reset: IFU first, then alternate
        rst = 1'b0;
        @(negedge ramclk);
        rst = 1'b1;
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h104;
        lsu_req_valid = 1'b1;
        lsu_req_write = 1'b0;
        lsu_req_addr  = 32'h40;
        lsu_req_size  = 2'd2;
        for (int g = 0; g < 4; g++) begin
            logic is_lsu;
            is_lsu = (g % 2) == 1;
            #1 chk("t2_grant", {ifu_req_ready, lsu_req_ready}, is_lsu ? 2'b01 : 2'b10);
            expect_resp(is_lsu, 32'hA0 + 32'(g), 1'b0);
            @(negedge ramclk);
            chk("t2_addr", mem_io_addr, is_lsu ? 32'h40 : 32'h104);
            chk("t2_size", io_byte_size, is_lsu ? 2'd2 : 2'd0);
            chk("t2_read", {mem_io_read, mem_io_write}, 2'b10);
            serve(1, 32'hA0 + 32'(g));
            @(negedge ramclk);
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;

        // LSU write, read data of the response must be zero
        lsu_req_valid = 1'b1;
        lsu_req_write = 1'b1;
        lsu_req_addr  = 32'h20;
        lsu_req_wdata = 32'h11223344;
        lsu_req_size  = 2'd1;
        #1 chk("t3_lsu_ready", {ifu_req_ready, lsu_req_ready}, 2'b01);
        expect_resp(1'b1, 32'h0, 1'b0);
        @(negedge ramclk);
        lsu_req_valid = 1'b0;
        lsu_req_addr  = 32'hBAD0_0000;
        lsu_req_wdata = 32'h0;
        chk("t3_write", {mem_io_read, mem_io_write}, 2'b01);
        chk("t3_addr", mem_io_addr, 32'h20);
        chk("t3_wdata", mem_io_wdata, 32'h11223344);
        chk("t3_size", io_byte_size, 2'd1);
        serve(2, 32'hFFFF_FFFF);
        @(negedge ramclk);

        // Ready held 3 edges while LSU waits: LSU only granted after DRAIN
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h300;
        #1 chk("t4_ifu_ready", ifu_req_ready, 1);
        expect_resp(1'b0, 32'h55, 1'b0);
        @(negedge ramclk);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b1;
        lsu_req_write = 1'b0;
        lsu_req_addr  = 32'h80;
        lsu_req_size  = 2'd0;
        #1 chk("t4_lsu_wait_busy", lsu_req_ready, 0);
        mem_io_ready = 1'b1;
        mem_io_rdata = 32'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge ramclk);
            #1 chk("t4_lsu_wait_drain", lsu_req_ready, 0);
        end
        mem_io_ready = 1'b0;
        mem_io_rdata = '0;
        #1 chk("t4_still_drain", {lsu_req_ready, arb_busy}, 2'b01);
        @(negedge ramclk);
        #1 chk("t4_lsu_granted", lsu_req_ready, 1);
        expect_resp(1'b1, 32'h66, 1'b0);
        @(negedge ramclk);
        lsu_req_valid = 1'b0;
        chk("t4_lsu_addr", mem_io_addr, 32'h80);
        chk("t4_lsu_read", {mem_io_read, mem_io_write}, 2'b10);
        serve(2, 32'h66);
        @(negedge ramclk);

        // Reset during BUSY aborts without a response
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h400;
        @(negedge ramclk);
        ifu_req_valid = 1'b0;
        chk("t5_busy_read", mem_io_read, 1);
        rst = 1'b0;
        @(negedge ramclk);
        chk("t5_read_drop", mem_io_read, 0);
        chk("t5_busy_drop", arb_busy, 0);
        chk("t5_no_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        chk("t5_rdata_clr", ifu_resp_rdata, 0);
        rst = 1'b1;
        @(negedge ramclk);

`ifdef MEM_ARB_TIMEOUT_EN
        // Timeout after 8 BUSY cycles with no ready
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h500;
        expect_resp(1'b0, 32'h0, 1'b1);
        @(negedge ramclk);
        ifu_req_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("t6_read_held", mem_io_read, 1);
            @(negedge ramclk);
        end
        chk("t6_read_held_last", mem_io_read, 1);
        @(negedge ramclk);
        chk("t6_read_drop", mem_io_read, 0);
        chk("t6_err_pulse", {ifu_resp_valid, ifu_resp_err}, 2'b11);
        @(negedge ramclk);
`endif

        repeat (2) @(negedge ramclk);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
